// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
interface if_fetch_stage_if;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_BUSYWAIT;
  logic [31:0] IMEM_READDATA;

  modport master (
    output IMEM_READ,
    output IMEM_ADDR,
    input  IMEM_BUSYWAIT,
    input  IMEM_READDATA
  );

  modport slave (
    input  IMEM_READ,
    input  IMEM_ADDR,
    output IMEM_BUSYWAIT,
    output IMEM_READDATA
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC sequencing, stall hold-over and branch redirect handling.
// Optional feature macro: IF_MISALIGN_TRAP_EN (sticky fault on misaligned redirect).
module if_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ENABLE,
  input  logic                   BRANCH_TAKEN,
  input  logic [31:0]            BRANCH_TARGET,
  if_fetch_stage_if.master       imem,
  output logic [31:0]            INSTRUCTION,
  output logic [31:0]            PC_PLUS_4,
  output logic                   FETCH_VALID,
  output logic                   IF_STALL,
  output logic                   FETCH_FAULT
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_word;
  logic [31:0] pending;
  logic        fault;
  logic        misaligned;
  logic [31:0] target;
  logic [31:0] pc_next4;

  assign target   = BRANCH_TARGET & 32'hFFFF_FFFC;
  assign pc_next4 = pc + 32'd4;

`ifdef IF_MISALIGN_TRAP_EN
  assign misaligned = BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign FETCH_FAULT = fault;

  always_comb begin
    imem.IMEM_READ = 1'b0;
    imem.IMEM_ADDR = {pc[31:2], 2'b00};
    INSTRUCTION    = '0;
    FETCH_VALID    = 1'b0;
    IF_STALL       = 1'b0;
    PC_PLUS_4      = pc_next4;
    if (!RESET && !fault) begin
      case (state)
        FETCH: begin
          imem.IMEM_READ = 1'b1;
          IF_STALL       = imem.IMEM_BUSYWAIT;
          FETCH_VALID    = !imem.IMEM_BUSYWAIT && !BRANCH_TAKEN;
          if (FETCH_VALID) INSTRUCTION = imem.IMEM_READDATA;
        end
        HOLD: begin
          FETCH_VALID = !BRANCH_TAKEN;
          if (FETCH_VALID) INSTRUCTION = hold_word;
        end
        DISCARD: begin
          imem.IMEM_READ = 1'b1;
          IF_STALL       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= FETCH;
      pc        <= RESET_VECTOR;
      hold_word <= '0;
      pending   <= '0;
      fault     <= 1'b0;
    end else if (misaligned) begin
      fault <= 1'b1;
      state <= FETCH;
    end else if (fault) begin
      // Frozen until an aligned redirect restarts fetching at its target.
      if (BRANCH_TAKEN) begin
        fault <= 1'b0;
        pc    <= target;
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (BRANCH_TAKEN) begin
            if (imem.IMEM_BUSYWAIT) begin
              pending <= target;
              state   <= DISCARD;
            end else begin
              pc <= target;
            end
          end else if (!imem.IMEM_BUSYWAIT) begin
            if (ENABLE) begin
              pc <= pc_next4;
            end else begin
              hold_word <= imem.IMEM_READDATA;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (BRANCH_TAKEN) begin
            pc    <= target;
            state <= FETCH;
          end else if (ENABLE) begin
            pc    <= pc_next4;
            state <= FETCH;
          end
        end
        DISCARD: begin
          // A redirect arriving in the completing cycle still wins over the stored one.
          if (BRANCH_TAKEN) pending <= target;
          if (!imem.IMEM_BUSYWAIT) begin
            pc    <= BRANCH_TAKEN ? target : pending;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage against a transaction-level fetch model.
module tb_if_fetch_stage;

`ifdef IF_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_PLUS_4;
  logic        FETCH_VALID;
  logic        IF_STALL;
  logic        FETCH_FAULT;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: architectural PC plus what the stage is currently doing with it.
  logic [31:0] m_pc;
  bit          m_holding;
  logic [31:0] m_held;
  bit          m_draining;
  logic [31:0] m_dtgt;
  bit          m_fault;

  if_fetch_stage_if imem_bus ();

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_bus.IMEM_READDATA = word_of(imem_bus.IMEM_ADDR);

  if_fetch_stage #(.RESET_VECTOR(32'h0000_0000)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ENABLE       (ENABLE),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET),
    .imem         (imem_bus),
    .INSTRUCTION  (INSTRUCTION),
    .PC_PLUS_4    (PC_PLUS_4),
    .FETCH_VALID  (FETCH_VALID),
    .IF_STALL     (IF_STALL),
    .FETCH_FAULT  (FETCH_FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_holding = 0; m_held = '0; m_draining = 0; m_dtgt = '0; m_fault = 0;
  endtask

  // One clock cycle: drive inputs, check predicted outputs, take the edge, advance the model.
  task automatic step(input bit en, input bit br, input logic [31:0] tgt, input bit busy);
    bit          e_read, e_valid, e_stall, mis;
    logic [31:0] e_instr, tg;
    ENABLE = en; BRANCH_TAKEN = br; BRANCH_TARGET = tgt; imem_bus.IMEM_BUSYWAIT = busy;
    #1;
    e_read = 0; e_valid = 0; e_stall = 0; e_instr = '0;
    if (m_fault) begin
    end else if (m_holding) begin
      e_valid = !br;
      e_instr = e_valid ? m_held : 32'h0;
    end else if (m_draining) begin
      e_read = 1; e_stall = 1;
    end else begin
      e_read = 1; e_stall = busy; e_valid = !busy && !br;
      e_instr = e_valid ? word_of(m_pc) : 32'h0;
    end
    chk("imem_read", {31'h0, imem_bus.IMEM_READ}, {31'h0, e_read});
    if (e_read) chk("imem_addr", imem_bus.IMEM_ADDR, m_pc);
    chk("fetch_valid", {31'h0, FETCH_VALID}, {31'h0, e_valid});
    chk("instruction", INSTRUCTION, e_instr);
    chk("pc_plus_4", PC_PLUS_4, m_pc + 32'd4);
    chk("if_stall", {31'h0, IF_STALL}, {31'h0, e_stall});
    chk("fetch_fault", {31'h0, FETCH_FAULT}, {31'h0, m_fault});
    @(posedge CLK);
    tg  = {tgt[31:2], 2'b00};
    mis = TRAP && br && (tgt[1:0] != 2'b00);
    if (mis) begin
      m_fault = 1; m_holding = 0; m_draining = 0;
    end else if (m_fault) begin
      if (br) begin m_pc = tg; m_fault = 0; end
    end else if (m_holding) begin
      if (br) begin m_pc = tg; m_holding = 0; end
      else if (en) begin m_pc = m_pc + 4; m_holding = 0; end
    end else if (m_draining) begin
      if (br) m_dtgt = tg;
      if (!busy) begin m_pc = m_dtgt; m_draining = 0; end
    end else if (br) begin
      if (busy) begin m_draining = 1; m_dtgt = tg; end
      else m_pc = tg;
    end else if (!busy) begin
      if (en) m_pc = m_pc + 4;
      else begin m_holding = 1; m_held = word_of(m_pc); end
    end
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] r, held_word;
    RESET = 1'b1; ENABLE = 1'b1; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0;
    imem_bus.IMEM_BUSYWAIT = 1'b0;
    model_reset();
    @(negedge CLK); @(negedge CLK);
    #1;
    chk("rst_read", {31'h0, imem_bus.IMEM_READ}, 32'h0);
    chk("rst_valid", {31'h0, FETCH_VALID}, 32'h0);
    chk("rst_instr", INSTRUCTION, 32'h0);
    chk("rst_stall", {31'h0, IF_STALL}, 32'h0);
    chk("rst_fault", {31'h0, FETCH_FAULT}, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;

    // Straight-line fetch from the reset vector: 0,4,8 then on to 0x10.
    for (int i = 0; i < 4; i++) step(1, 0, '0, 0);
    // Three busy cycles at 0x10, then the word arrives.
    for (int i = 0; i < 3; i++) step(1, 0, '0, 1);
    #1 chk("busy_done_pp4", PC_PLUS_4, 32'h14);
    step(1, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0);
    // Downstream stall at 0x20 for two cycles.
    held_word = word_of(32'h20);
    step(0, 0, '0, 0);
    #1 chk("hold_instr", INSTRUCTION, held_word);
    step(0, 0, '0, 0);
    step(1, 0, '0, 0);
    #1 chk("after_hold_addr", imem_bus.IMEM_ADDR, 32'h24);
    for (int i = 0; i < 7; i++) step(1, 0, '0, 0);
    // Redirect to 0x100 while the access at 0x40 is still in flight.
    step(1, 1, 32'h100, 1);
    #1 chk("discard_addr", imem_bus.IMEM_ADDR, 32'h40);
    step(1, 0, '0, 1);
    step(1, 0, '0, 0);
    #1 chk("redirect_addr", imem_bus.IMEM_ADDR, 32'h100);
    step(1, 0, '0, 0);
    // Last redirect during a discard wins.
    step(1, 1, 32'h300, 1);
    step(1, 1, 32'h500, 1);
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    // Wrap at the top of the address space.
    step(1, 1, 32'hFFFF_FFFC, 0);
    #1 chk("wrap_pp4", PC_PLUS_4, 32'h0);
    step(1, 0, '0, 0);
    #1 chk("wrap_addr", imem_bus.IMEM_ADDR, 32'h0);
    step(1, 0, '0, 0);
    // Misaligned redirect.
    step(1, 1, 32'h102, 0);
    #1;
    if (TRAP) begin
      chk("mis_fault", {31'h0, FETCH_FAULT}, 32'h1);
      chk("mis_read", {31'h0, imem_bus.IMEM_READ}, 32'h0);
    end else begin
      chk("mis_addr", imem_bus.IMEM_ADDR, 32'h100);
      chk("mis_fault", {31'h0, FETCH_FAULT}, 32'h0);
    end
    step(1, 0, '0, 0);
    step(1, 1, 32'h200, 0);
    step(1, 0, '0, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      if ($urandom_range(0, 7) != 0) r = r & 32'hFFFF_FFFC;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, r, $urandom_range(0, 2) == 0);
    end

    // Asynchronous reset in the middle of a busy access.
    ENABLE = 1'b1; BRANCH_TAKEN = 1'b0; imem_bus.IMEM_BUSYWAIT = 1'b1;
    #2 RESET = 1'b1;
    #1;
    chk("arst_read", {31'h0, imem_bus.IMEM_READ}, 32'h0);
    chk("arst_valid", {31'h0, FETCH_VALID}, 32'h0);
    chk("arst_stall", {31'h0, IF_STALL}, 32'h0);
    chk("arst_pp4", PC_PLUS_4, 32'h4);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
